// File: rtl/edge_pkg.sv
// Shared constants and window type for the edge-detector pipeline.
// The Gaussian convolution stage imports win_t so both ends agree on element order.
package edge_pkg;

  localparam int COLDepth     = 8;
  localparam int Matrix_Scale = 5;
  localparam int Matrix_Size  = Matrix_Scale * Matrix_Scale;
  localparam int LB_COUNT     = Matrix_Scale - 1;

  typedef logic [COLDepth-1:0] pix_t;

  // Element r*Matrix_Scale+c: r=0 is the top row, c=0 the left column.
  typedef logic [Matrix_Size-1:0][COLDepth-1:0] win_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. The read port returns the stored value at the
// current address, so a write in the same cycle sees the old contents first.
module line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_o
);

  pix_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/gauss_window_gen.sv
// Streaming 5x5 window generator: four cascaded row buffers feed a 5x5 shift
// register, and one window is emitted per interior pixel position.
module gauss_window_gen
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic                          pix_sof,
  input  logic [COLDepth-1:0]           pix_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output win_t                          win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          win_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] EDGE_C  = CW'(Matrix_Scale - 1);
  localparam logic [RW-1:0] EDGE_R  = RW'(Matrix_Scale - 1);
  localparam logic [CW-1:0] HALF_C  = CW'(Matrix_Scale / 2);
  localparam logic [RW-1:0] HALF_R  = RW'(Matrix_Scale / 2);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          accept, emit;

  win_t          win_q, win_d, win_shift;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          win_last_q, win_last_d;

  pix_t lb_rdata [LB_COUNT];
  pix_t lb_wdata [LB_COUNT];
  pix_t col_in   [Matrix_Scale];

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel lands at (0,0) whatever the counters say.
  assign pos_col = pix_sof ? '0 : col_q;
  assign pos_row = pix_sof ? '0 : row_q;
  assign emit    = accept && (pos_row >= EDGE_R) && (pos_col >= EDGE_C);

  genvar gi, gj;
  generate
    for (gi = 0; gi < LB_COUNT; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wdata[gi] = pix_data;
      end else begin : g_tail
        assign lb_wdata[gi] = lb_rdata[gi-1];
      end
      line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
        .clk    (clk),
        .we_i   (accept),
        .addr_i (pos_col),
        .wdata_i(lb_wdata[gi]),
        .rdata_o(lb_rdata[gi])
      );
    end

    // Incoming column, top to bottom: oldest row buffer down to the live pixel.
    for (gi = 0; gi < Matrix_Scale; gi++) begin : g_col
      if (gi == Matrix_Scale - 1) begin : g_live
        assign col_in[gi] = pix_data;
      end else begin : g_buf
        assign col_in[gi] = lb_rdata[LB_COUNT-1-gi];
      end
    end

    for (gi = 0; gi < Matrix_Scale; gi++) begin : g_wr
      for (gj = 0; gj < Matrix_Scale; gj++) begin : g_wc
        if (gj == Matrix_Scale - 1) begin : g_new
          assign win_shift[gi*Matrix_Scale+gj] = col_in[gi];
        end else begin : g_old
          assign win_shift[gi*Matrix_Scale+gj] = win_q[gi*Matrix_Scale+gj+1];
        end
      end
    end
  endgenerate

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_col == COL_MAX) begin
        col_d = '0;
        row_d = (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // The window register doubles as win_data; it only moves on accept, which
  // cannot happen while a window is stalled, so stalled outputs stay put.
  always_comb begin
    win_d       = accept ? win_shift : win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;
    if (accept) begin
      win_valid_d = emit;
      if (emit) begin
        win_row_d  = pos_row - HALF_R;
        win_col_d  = pos_col - HALF_C;
        win_last_d = (pos_row == ROW_MAX) && (pos_col == COL_MAX);
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_gauss_window_gen.sv
// Randomized bench for gauss_window_gen on an 8x6 image, checked against a
// frame-array reference model that builds each expected window directly.
module tb_gauss_window_gen;
  import edge_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       win_ready = 1'b0;
  logic       pix_ready;
  logic       win_valid;
  win_t       win_data;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       win_last;

  always #5 clk = ~clk;

  gauss_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_sof  (pix_sof),
    .pix_data (pix_data),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_row  (win_row),
    .win_col  (win_col),
    .win_last (win_last)
  );

  typedef struct {
    win_t       data;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
  } win_rec_t;

  win_rec_t   exp_q[$];
  win_rec_t   first_win, last_win;
  bit         first_got;
  logic [7:0] frame [H][W];
  int         mr = 0, mc = 0;
  int         vectors = 0, miscompares = 0;
  int         win_seen = 0, last_seen = 0;
  int         valid_pct = 100, ready_pct = 100, stall_left = 0;
  bit         rand_data = 0;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: remember every pixel at its frame position; an interior pixel
  // yields the 5x5 block ending at it.
  task automatic model_accept(input logic [7:0] d, input logic sof);
    win_rec_t w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    frame[mr][mc] = d;
    if (mr >= 4 && mc >= 4) begin
      w.data = '0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          w.data[i*5+j] = frame[mr-4+i][mc-4+j];
      w.row  = 3'(mr - 2);
      w.col  = 3'(mc - 2);
      w.last = (mr == H-1) && (mc == W-1);
      exp_q.push_back(w);
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic sof, output bit acc);
    logic rdy;
    bit   pend;
    @(negedge clk);
    pend = exp_q.size() > 0;
    if (pend && stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else begin
      rdy = ($urandom_range(99) < ready_pct);
    end
    pix_valid = v;
    pix_data  = d;
    pix_sof   = sof;
    win_ready = rdy;
    #1;
    check("win_valid", win_valid, pend);
    check("pix_ready", pix_ready, !pend || rdy);
    if (pend) begin
      check("win_data", win_data, exp_q[0].data);
      check("win_row", win_row, exp_q[0].row);
      check("win_col", win_col, exp_q[0].col);
      check("win_last", win_last, exp_q[0].last);
      if (rdy) begin
        $display("window row=%0d col=%0d last=%0d d0=%02h d24=%02h",
                 win_row, win_col, win_last, win_data[0], win_data[24]);
        if (!first_got) begin
          first_win.data = win_data;
          first_win.row  = win_row;
          first_win.col  = win_col;
          first_win.last = win_last;
          first_got = 1'b1;
        end
        last_win.data = win_data;
        last_win.row  = win_row;
        last_win.col  = win_col;
        last_win.last = win_last;
        win_seen++;
        if (win_last) last_seen++;
        void'(exp_q.pop_front());
      end
    end
    acc = v && (!pend || rdy);
    if (acc) model_accept(d, sof);
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic sof);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 200) begin
      cycle(logic'($urandom_range(99) < valid_pct), d, sof, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_pixels(input int npix, input bit sof_first);
    for (int k = 0; k < npix; k++) begin
      logic [7:0] d;
      d = rand_data ? 8'($urandom) : 8'((k / W) * 16 + (k % W));
      send_pixel(d, sof_first && (k == 0));
    end
  endtask

  task automatic drain(input int n);
    bit acc;
    ready_pct = 100;
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, win_valid, 0);
    check({tag, "_data"}, win_data, 0);
    check({tag, "_row"}, win_row, 0);
    check({tag, "_col"}, win_col, 0);
    check({tag, "_last"}, win_last, 0);
    check({tag, "_pready"}, pix_ready, 1);
  endtask

  initial begin
    int base, lbase;

    #2 reset = 1'b0;
    @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Gap-free frame with spec-level constant checks on the first and last window.
    first_got = 0; base = win_seen; lbase = last_seen;
    send_pixels(W*H, 1'b1);
    drain(3);
    check("A_nwin", win_seen - base, 8);
    check("A_nlast", last_seen - lbase, 1);
    check("A_first_row", first_win.row, 2);
    check("A_first_col", first_win.col, 2);
    check("A_first_d0", first_win.data[0], 8'h00);
    check("A_first_d12", first_win.data[12], 8'h22);
    check("A_first_d24", first_win.data[24], 8'h44);
    check("A_last_row", last_win.row, 3);
    check("A_last_col", last_win.col, 5);
    check("A_last_flag", last_win.last, 1);

    // Consumer stall of three cycles on the first window.
    base = win_seen;
    stall_left = 3;
    send_pixels(W*H, 1'b1);
    drain(3);
    check("B_nwin", win_seen - base, 8);
    check("B_stall_used", stall_left, 0);

    // Random valid gaps and ready back-pressure, structured then random pixels.
    valid_pct = 50;
    for (int p = 0; p < 2; p++) begin
      rand_data = (p == 1);
      ready_pct = 70;
      base = win_seen;
      send_pixels(W*H, 1'b1);
      drain(4);
      check("C_nwin", win_seen - base, 8);
    end
    valid_pct = 100;
    rand_data = 0;

    // Start-of-frame at what would be pixel (2,3) restarts the counters.
    base = win_seen;
    send_pixels(2*W + 3, 1'b1);
    check("D_no_early_win", win_seen - base, 0);
    first_got = 0;
    send_pixels(W*H, 1'b1);
    drain(3);
    check("D_nwin", win_seen - base, 8);
    check("D_first_row", first_win.row, 2);
    check("D_first_col", first_win.col, 2);

    // Reset pulse mid-row 5 while a window is pending.
    send_pixels(5*W + 5, 1'b1);
    @(negedge clk);
    check("E_pending", win_valid, 1);
    pix_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_outputs("E_rst");
    exp_q.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    reset = 1'b1;
    base = win_seen;
    send_pixels(W*H, 1'b0);
    drain(3);
    check("E_nwin", win_seen - base, 8);

    // Two frames back to back.
    base = win_seen; lbase = last_seen;
    ready_pct = 100;
    send_pixels(W*H, 1'b1);
    send_pixels(W*H, 1'b1);
    drain(3);
    check("F_nwin", win_seen - base, 16);
    check("F_nlast", last_seen - lbase, 2);
    check("F_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
